// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D memory port arbiter: FSM encoding,
// requester select values and the round-robin pick.
package aquila_mem_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic SEL_I = 1'b0;
   localparam logic SEL_D = 1'b1;

   // With both sides pending, the side not granted last time wins.
   function automatic logic next_sel(input logic i_pend, input logic d_pend,
                                     input logic last_d);
      if (i_pend && d_pend) return last_d ? SEL_I : SEL_D;
      return d_pend ? SEL_D : SEL_I;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// I-side, D-side and downstream memory port signals of the arbiter.
// master: the arbiter itself; slave: the requesters plus memory controller.
interface mem_port_arbiter_if #(
   parameter int XLEN   = 64,
   parameter int CLSIZE = 128
);
   // Requesters hold strobe high until their done pulse and drop it the
   // cycle after; M_strobe_o is a one-cycle pulse answered by one M_done_i.
   logic              I_strobe_i;
   logic [XLEN-1:0]   I_addr_i;
   logic              I_done_o;
   logic [CLSIZE-1:0] I_data_o;
   logic              D_strobe_i;
   logic [XLEN-1:0]   D_addr_i;
   logic              D_rw_i;
   logic [CLSIZE-1:0] D_data_i;
   logic              D_done_o;
   logic [CLSIZE-1:0] D_data_o;
   logic              M_strobe_o;
   logic [XLEN-1:0]   M_addr_o;
   logic              M_rw_o;
   logic [CLSIZE-1:0] M_data_o;
   logic              M_done_i;
   logic [CLSIZE-1:0] M_data_i;

   modport master (
      input  I_strobe_i, I_addr_i, D_strobe_i, D_addr_i, D_rw_i, D_data_i,
             M_done_i, M_data_i,
      output I_done_o, I_data_o, D_done_o, D_data_o,
             M_strobe_o, M_addr_o, M_rw_o, M_data_o
   );

   modport slave (
      output I_strobe_i, I_addr_i, D_strobe_i, D_addr_i, D_rw_i, D_data_i,
             M_done_i, M_data_i,
      input  I_done_o, I_data_o, D_done_o, D_data_o,
             M_strobe_o, M_addr_o, M_rw_o, M_data_o
   );
endinterface

// File: rtl/mem_port_arbiter_capture.sv
// One requester's capture slot: pending flag plus address/rw/data registers,
// loaded on a new strobe and freed by the arbiter's response cycle.
module mem_req_capture #(
   parameter int XLEN   = 64,
   parameter int CLSIZE = 128
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              strobe_i,
   input  logic [XLEN-1:0]   addr_i,
   input  logic              rw_i,
   input  logic [CLSIZE-1:0] data_i,
   input  logic              release_i,
   output logic              pend_o,
   output logic [XLEN-1:0]   addr_o,
   output logic              rw_o,
   output logic [CLSIZE-1:0] data_o
);

   logic              pend_q, pend_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic              rw_q, rw_d;
   logic [CLSIZE-1:0] data_q, data_d;

   // release_i also blocks capture: the strobe is still high in that cycle.
   always_comb begin
      pend_d = pend_q;
      addr_d = addr_q;
      rw_d   = rw_q;
      data_d = data_q;
      if (release_i) begin
         pend_d = 1'b0;
      end else if (strobe_i && !pend_q) begin
         pend_d = 1'b1;
         addr_d = addr_i;
         rw_d   = rw_i;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q <= 1'b0;
         addr_q <= '0;
         rw_q   <= 1'b0;
         data_q <= '0;
      end else begin
         pend_q <= pend_d;
         addr_q <= addr_d;
         rw_q   <= rw_d;
         data_q <= data_d;
      end
   end

   assign pend_o = pend_q;
   assign addr_o = addr_q;
   assign rw_o   = rw_q;
   assign data_o = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one cache-line memory port between the I-cache
// refill path and the D-cache refill/write-back path, one transaction at a time.
module mem_port_arbiter
   import aquila_mem_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int CLSIZE = 128
) (
   input  logic                clk_i,
   input  logic                rst_i,
   mem_port_arbiter_if.master  bus,
   output logic                busy_o,
   output logic                grant_d_o,
   output logic [1:0]          dbg_state_o
);

   logic [1:0]        state_q, state_d;
   logic              sel_q, sel_d;
   logic              last_d_q, last_d_d;
   logic [CLSIZE-1:0] i_data_q, i_data_d;
   logic [CLSIZE-1:0] d_data_q, d_data_d;

   logic              i_pend, d_pend;
   logic [XLEN-1:0]   i_addr, d_addr;
   logic              i_rw, d_rw;
   logic [CLSIZE-1:0] i_wdata, d_wdata;
   logic              i_release, d_release;
   logic              drive_m;

   assign i_release = (state_q == S_RESP) && (sel_q == SEL_I);
   assign d_release = (state_q == S_RESP) && (sel_q == SEL_D);

   // The I side only reads, so its rw/data registers always hold zero.
   mem_req_capture #(.XLEN(XLEN), .CLSIZE(CLSIZE)) u_cap_i (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .strobe_i  (bus.I_strobe_i),
      .addr_i    (bus.I_addr_i),
      .rw_i      (1'b0),
      .data_i    ({CLSIZE{1'b0}}),
      .release_i (i_release),
      .pend_o    (i_pend),
      .addr_o    (i_addr),
      .rw_o      (i_rw),
      .data_o    (i_wdata)
   );

   mem_req_capture #(.XLEN(XLEN), .CLSIZE(CLSIZE)) u_cap_d (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .strobe_i  (bus.D_strobe_i),
      .addr_i    (bus.D_addr_i),
      .rw_i      (bus.D_rw_i),
      .data_i    (bus.D_data_i),
      .release_i (d_release),
      .pend_o    (d_pend),
      .addr_o    (d_addr),
      .rw_o      (d_rw),
      .data_o    (d_wdata)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      last_d_d = last_d_q;
      i_data_d = i_data_q;
      d_data_d = d_data_q;
      case (state_q)
         S_IDLE: begin
            if (i_pend || d_pend) begin
               sel_d    = next_sel(i_pend, d_pend, last_d_q);
               last_d_d = (sel_d == SEL_D);
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (bus.M_done_i) begin
               if (sel_q == SEL_D) d_data_d = bus.M_data_i;
               else                i_data_d = bus.M_data_i;
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         sel_q    <= SEL_I;
         last_d_q <= 1'b0;
         i_data_q <= '0;
         d_data_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         last_d_q <= last_d_d;
         i_data_q <= i_data_d;
         d_data_q <= d_data_d;
      end
   end

   // Downstream fields come straight from the held capture registers,
   // which cannot change while their side is pending.
   assign drive_m        = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign bus.M_strobe_o = (state_q == S_ISSUE);
   assign bus.M_addr_o   = drive_m ? ((sel_q == SEL_D) ? d_addr  : i_addr)  : '0;
   assign bus.M_rw_o     = drive_m ? ((sel_q == SEL_D) ? d_rw    : i_rw)    : 1'b0;
   assign bus.M_data_o   = drive_m ? ((sel_q == SEL_D) ? d_wdata : i_wdata) : '0;

   assign bus.I_done_o = i_release;
   assign bus.D_done_o = d_release;
   assign bus.I_data_o = i_data_q;
   assign bus.D_data_o = d_data_q;

   assign busy_o      = (state_q != S_IDLE);
   assign grant_d_o   = last_d_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected downstream requests and
// responses are queued by the stimulus and checked by a negedge monitor.
module tb_mem_port_arbiter;

   localparam int XLEN   = 64;
   localparam int CLSIZE = 128;
   localparam int WM     = 2 + XLEN + CLSIZE;
   localparam int WR     = 1 + CLSIZE;

   logic       clk;
   logic       rst;
   logic       busy;
   logic       grant_d;
   logic [1:0] dbg_state;

   mem_port_arbiter_if #(.XLEN(XLEN), .CLSIZE(CLSIZE)) bus ();

   mem_port_arbiter #(.XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus),
      .busy_o      (busy),
      .grant_d_o   (grant_d),
      .dbg_state_o (dbg_state)
   );

   logic [WM-1:0]     exp_m_q[$];
   logic [WR-1:0]     exp_r_q[$];
   logic [CLSIZE-1:0] mem_rdata_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int strobe_cnt = 0;
   int last_strobe_cyc = -10;
   int mdone_cyc = -10;
   int mem_delay = 5;
   int force_tok = 0;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- memory responder ----------------
   initial begin : responder
      int cnt;
      int force_seen;
      cnt = 0;
      force_seen = 0;
      bus.M_done_i = 1'b0;
      bus.M_data_i = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.M_done_i = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.M_done_i = 1'b1;
               bus.M_data_i = (mem_rdata_q.size() > 0) ? mem_rdata_q.pop_front() : '0;
            end
         end else if (force_tok != force_seen) begin
            force_seen   = force_tok;
            bus.M_done_i = 1'b1;
            bus.M_data_i = {CLSIZE{1'b1}};
         end
         if (bus.M_strobe_o) cnt = mem_delay;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic check_resp(input logic side, input logic [CLSIZE-1:0] data);
      logic [WR-1:0] e;
      checks++;
      if (exp_r_q.size() == 0) begin
         errors++;
         $display("FAIL resp_unexpected: side=%0d data=%h, required no done pulse", side, data);
      end else begin
         e = exp_r_q.pop_front();
         if ({side, data} !== e) begin
            errors++;
            $display("FAIL resp: got side=%0d data=%h, required side=%0d data=%h",
                     side, data, e[WR-1], e[CLSIZE-1:0]);
         end
      end
      checks++;
      if (cyc != mdone_cyc + 1) begin
         errors++;
         $display("FAIL done_latency: done at cyc %0d, required %0d", cyc, mdone_cyc + 1);
      end
   endtask

   initial forever begin : monitor
      logic [WM-1:0] e;
      logic [WM-1:0] a;
      @(negedge clk);
      if (bus.M_done_i) mdone_cyc = cyc;
      if (bus.M_strobe_o) begin
         strobe_cnt++;
         last_strobe_cyc = cyc;
         a = {grant_d, bus.M_rw_o, bus.M_addr_o, bus.M_data_o};
         checks++;
         if (exp_m_q.size() == 0) begin
            errors++;
            $display("FAIL m_unexpected: strobe with grant/rw/addr/data %h, required none", a);
         end else begin
            e = exp_m_q.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL m_req: got grant/rw/addr/data %h, required %h", a, e);
            end
         end
      end
      if (bus.I_done_o) check_resp(1'b0, bus.I_data_o);
      if (bus.D_done_o) check_resp(1'b1, bus.D_data_o);
   end

   // ---------------- driver tasks ----------------
   task automatic chk(input string name, input logic [WM-1:0] act, input logic [WM-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"},     WM'(busy), '0);
      chk({tag, "_state"},    WM'(dbg_state), '0);
      chk({tag, "_grant_d"},  WM'(grant_d), '0);
      chk({tag, "_m_strobe"}, WM'(bus.M_strobe_o), '0);
      chk({tag, "_m_addr"},   WM'(bus.M_addr_o), '0);
      chk({tag, "_m_rw"},     WM'(bus.M_rw_o), '0);
      chk({tag, "_m_data"},   WM'(bus.M_data_o), '0);
      chk({tag, "_i_done"},   WM'(bus.I_done_o), '0);
      chk({tag, "_d_done"},   WM'(bus.D_done_o), '0);
      chk({tag, "_i_data"},   WM'(bus.I_data_o), '0);
      chk({tag, "_d_data"},   WM'(bus.D_data_o), '0);
   endtask

   task automatic i_req(input logic [XLEN-1:0] addr, output int t_req);
      bit seen;
      @(posedge clk);
      #1;
      bus.I_strobe_i = 1'b1;
      bus.I_addr_i   = addr;
      t_req = cyc;
      seen = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (bus.I_done_o) begin
            seen = 1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL i_timeout: no I_done_o for addr %h, required within 300 cycles", addr);
      end
      @(posedge clk);
      #1;
      bus.I_strobe_i = 1'b0;
   endtask

   task automatic d_req(input logic [XLEN-1:0] addr, input logic rw,
                        input logic [CLSIZE-1:0] data);
      bit seen;
      @(posedge clk);
      #1;
      bus.D_strobe_i = 1'b1;
      bus.D_addr_i   = addr;
      bus.D_rw_i     = rw;
      bus.D_data_i   = data;
      seen = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (bus.D_done_o) begin
            seen = 1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL d_timeout: no D_done_o for addr %h, required within 300 cycles", addr);
      end
      @(posedge clk);
      #1;
      bus.D_strobe_i = 1'b0;
   endtask

   task automatic wait_strobe(input string name);
      bit seen;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.M_strobe_o) begin
            seen = 1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: no M_strobe_o, required within 100 cycles", name);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin : stimulus
      int t;
      int sc;
      logic [CLSIZE-1:0] rd;
      rst = 1'b1;
      bus.I_strobe_i = 1'b0;
      bus.I_addr_i   = '0;
      bus.D_strobe_i = 1'b0;
      bus.D_addr_i   = '0;
      bus.D_rw_i     = 1'b0;
      bus.D_data_i   = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_zero("reset");

      // Single I read, memory answers 5 cycles after the strobe.
      rd = 128'h0123456789ABCDEF0123456789ABCDEF;
      mem_delay = 5;
      exp_m_q.push_back({1'b0, 1'b0, 64'h8000_0040, 128'h0});
      mem_rdata_q.push_back(rd);
      exp_r_q.push_back({1'b0, rd});
      i_req(64'h8000_0040, t);
      chk("issue_latency", WM'(last_strobe_cyc), WM'(t + 2));
      chk("t1_i_data_hold", WM'(bus.I_data_o), WM'(rd));

      // Simultaneous I read and D write after reset: D wins first.
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      mem_delay = 3;
      exp_m_q.push_back({1'b1, 1'b1, 64'h8000_1000, {16{8'hAA}}});
      exp_m_q.push_back({1'b0, 1'b0, 64'h8000_0080, 128'h0});
      mem_rdata_q.push_back({8{16'h5555}});
      mem_rdata_q.push_back({8{16'h1111}});
      exp_r_q.push_back({1'b1, {8{16'h5555}}});
      exp_r_q.push_back({1'b0, {8{16'h1111}}});
      fork
         d_req(64'h8000_1000, 1'b1, {16{8'hAA}});
         i_req(64'h8000_0080, t);
      join

      // Both sides requesting continuously: D, I, D, I, D, I.
      mem_delay = 2;
      sc = strobe_cnt;
      for (int j = 0; j < 6; j++) begin
         rd = {96'h0, 32'hF000_0000 + 32'(j)};
         if (j % 2 == 0)
            exp_m_q.push_back({1'b1, 1'b0, 64'h8000_2000 + 64'(j / 2) * 64'h40,
                               {96'h0, 32'hC0DE_0000 + 32'(j / 2)}});
         else
            exp_m_q.push_back({1'b0, 1'b0, 64'h8000_0100 + 64'(j / 2) * 64'h40, 128'h0});
         mem_rdata_q.push_back(rd);
         exp_r_q.push_back({(j % 2 == 0) ? 1'b1 : 1'b0, rd});
      end
      fork
         begin
            for (int k = 0; k < 3; k++)
               d_req(64'h8000_2000 + 64'(k) * 64'h40, 1'b0, {96'h0, 32'hC0DE_0000 + 32'(k)});
         end
         begin
            int tt;
            for (int k = 0; k < 3; k++) i_req(64'h8000_0100 + 64'(k) * 64'h40, tt);
         end
      join
      repeat (4) @(posedge clk);
      chk("rr_strobe_count", WM'(strobe_cnt - sc), WM'(6));

      // Spurious M_done_i while idle must be ignored.
      @(posedge clk);
      #1 force_tok++;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("spurious_busy", WM'(busy), '0);
      chk("spurious_i_data", WM'(bus.I_data_o), WM'({96'h0, 32'hF000_0005}));

      // D strobe held through a long WAIT with changing inputs.
      mem_delay = 8;
      sc = strobe_cnt;
      exp_m_q.push_back({1'b1, 1'b0, 64'h8000_3000, {4{32'h1234_5678}}});
      mem_rdata_q.push_back({4{32'h0BAD_F00D}});
      exp_r_q.push_back({1'b1, {4{32'h0BAD_F00D}}});
      fork
         d_req(64'h8000_3000, 1'b0, {4{32'h1234_5678}});
         begin
            wait_strobe("hold_strobe");
            repeat (2) @(posedge clk);
            #1;
            bus.D_addr_i = 64'hDEAD_BEEF_0000_0000;
            bus.D_data_i = {CLSIZE{1'b1}};
            bus.D_rw_i   = 1'b1;
            @(negedge clk);
            chk("wait_addr_hold", WM'(bus.M_addr_o), WM'(64'h8000_3000));
            chk("wait_data_hold", WM'(bus.M_data_o), WM'({4{32'h1234_5678}}));
            chk("wait_rw_hold", WM'(bus.M_rw_o), '0);
            chk("wait_state", WM'(dbg_state), WM'(2));
         end
      join
      repeat (6) @(posedge clk);
      chk("hold_strobe_count", WM'(strobe_cnt - sc), WM'(1));

      // Reset during WAIT abandons the transaction.
      mem_delay = 6;
      exp_m_q.push_back({1'b0, 1'b0, 64'h8000_0200, 128'h0});
      mem_rdata_q.push_back({4{32'hBAD0_BAD0}});
      @(posedge clk);
      #1;
      bus.I_strobe_i = 1'b1;
      bus.I_addr_i   = 64'h8000_0200;
      wait_strobe("rst_strobe");
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.I_strobe_i = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_zero("wait_reset");
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("stale_done_busy", WM'(busy), '0);

      mem_delay = 3;
      exp_m_q.push_back({1'b0, 1'b0, 64'h8000_0300, 128'h0});
      mem_rdata_q.push_back({8{16'h7777}});
      exp_r_q.push_back({1'b0, {8{16'h7777}}});
      i_req(64'h8000_0300, t);
      chk("post_reset_latency", WM'(last_strobe_cyc), WM'(t + 2));

      repeat (5) @(posedge clk);
      chk("exp_m_empty", WM'(exp_m_q.size()), '0);
      chk("exp_r_empty", WM'(exp_r_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
